// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path types, FSM encoding and reset vector default
package cpu_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] instr_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam addr_t RESET_VECTOR_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - sequential PC successor, wired beside pc_fetch_unit by the integrator
module pc_adder
    import cpu_pkg::*;
(
    input  addr_t current_address,
    output addr_t next_address
);

    assign next_address = current_address + 16'd1;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch FSM with redirect/halt handling
// Optional PC wrap trap enabled by defining PC_WRAP_TRAP_EN (adds fetch_fault port).
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output addr_t       pc_out,
    input  addr_t       next_address,
    input  logic        branch_taken,
    input  addr_t       branch_target,
    input  logic        stall,
    input  logic        halt_req,
    output logic        imem_req_valid,
    output addr_t       imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  instr_t      imem_rsp_data,
    output logic        instr_valid,
    output instr_t      instr,
    output logic        halted
`ifdef PC_WRAP_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    fetch_state_t state;
    logic         redir_pend;
    addr_t        redir_target;
    logic         halt_pend;
    logic         wrap_hit;

`ifdef PC_WRAP_TRAP_EN
    assign wrap_hit = (next_address < pc_out);
`else
    assign wrap_hit = 1'b0;
`endif

    assign imem_req_addr = pc_out;
    assign halted        = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_REQ;
            pc_out         <= RESET_VECTOR;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            redir_pend     <= 1'b0;
            redir_target   <= '0;
            halt_pend      <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
            fetch_fault    <= 1'b0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (!imem_req_valid) begin
                        // Idle redirect lands in pc_out directly; a request raised on the
                        // same edge already carries the new address.
                        if (branch_taken) begin
                            pc_out <= branch_target;
                        end
                        if (halt_req) begin
                            state <= S_HALT;
                        end else if (!stall) begin
                            imem_req_valid <= 1'b1;
                        end
                    end else begin
                        if (branch_taken) begin
                            redir_pend   <= 1'b1;
                            redir_target <= branch_target;
                        end
                        if (halt_req) begin
                            halt_pend <= 1'b1;
                        end
                        if (imem_req_ready) begin
                            imem_req_valid <= 1'b0;
                            state          <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        redir_pend <= 1'b0;
                        halt_pend  <= 1'b0;
                        if (branch_taken) begin
                            pc_out <= branch_target;
                        end else if (redir_pend) begin
                            pc_out <= redir_target;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_valid <= 1'b1;
`ifdef PC_WRAP_TRAP_EN
                            if (wrap_hit) begin
                                fetch_fault <= 1'b1;
                            end else begin
                                pc_out <= next_address;
                            end
`else
                            pc_out <= next_address;
`endif
                        end
                        if (halt_pend || halt_req ||
                            (wrap_hit && !branch_taken && !redir_pend)) begin
                            state <= S_HALT;
                        end else begin
                            state <= S_REQ;
                        end
                    end else begin
                        if (branch_taken) begin
                            redir_pend   <= 1'b1;
                            redir_target <= branch_target;
                        end
                        if (halt_req) begin
                            halt_pend <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    imem_req_valid <= 1'b0;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized scenario bench for pc_fetch_unit with transaction-level model
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    localparam addr_t RV = 16'h0000;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    addr_t  pc_out;
    addr_t  next_address;
    logic   branch_taken = 1'b0;
    addr_t  branch_target = '0;
    logic   stall = 1'b0;
    logic   halt_req = 1'b0;
    logic   imem_req_valid;
    addr_t  imem_req_addr;
    logic   imem_req_ready = 1'b0;
    logic   imem_rsp_valid = 1'b0;
    instr_t imem_rsp_data = '0;
    logic   instr_valid;
    instr_t instr;
    logic   halted;
`ifdef PC_WRAP_TRAP_EN
    logic   fetch_fault;
`endif

    int checks = 0;
    int errors = 0;
    addr_t model_pc;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .next_address(next_address),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .halt_req(halt_req), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
        .halted(halted)
`ifdef PC_WRAP_TRAP_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    pc_adder u_adder (.current_address(pc_out), .next_address(next_address));

    task automatic clear_inputs();
        branch_taken = 1'b0; branch_target = '0; stall = 1'b0; halt_req = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    endtask

    task automatic do_reset(input bit halt_at_release);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        halt_req = halt_at_release;
        rst_n = 1'b1;
        model_pc = RV;
    endtask

    // Memory-side driver: waits for a request, optionally delays ready, then answers.
    // An injected branch/halt lands in the first cycle after the handshake.
    task automatic mem_txn(input int rdy_dly, input int rsp_dly, input instr_t data,
                           input bit inj_br, input addr_t tgt, input bit inj_halt,
                           input bit tog_stall, output bit got_req, output addr_t addr,
                           output bit stable, output bit iv, output instr_t ins,
                           output addr_t pc_after);
        got_req = 1'b0; stable = 1'b1; iv = 1'b0; ins = '0; addr = '0; pc_after = '0;
        for (int i = 0; i < 40 && !got_req; i++) begin
            if (imem_req_valid === 1'b1) got_req = 1'b1;
            else @(negedge clk);
        end
        if (!got_req) return;
        addr = imem_req_addr;
        for (int i = 0; i < rdy_dly; i++) begin
            imem_req_ready = 1'b0;
            if (tog_stall) stall = ~stall;
            @(negedge clk);
            if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) stable = 1'b0;
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        stall = 1'b0;
        if (imem_req_valid !== 1'b0) stable = 1'b0;
        for (int i = 0; i <= rsp_dly; i++) begin
            branch_taken   = inj_br && (i == 0);
            branch_target  = tgt;
            halt_req       = inj_halt && (i == 0);
            imem_rsp_valid = (i == rsp_dly);
            imem_rsp_data  = (i == rsp_dly) ? data : 16'($urandom);
            @(negedge clk);
        end
        branch_taken = 1'b0; halt_req = 1'b0; imem_rsp_valid = 1'b0;
        iv = instr_valid; ins = instr; pc_after = pc_out;
    endtask

    task automatic idle_branch(input addr_t tgt);
        branch_taken = 1'b1; branch_target = tgt;
        @(negedge clk);
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (pc_out !== RV) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, RV); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
`ifdef PC_WRAP_TRAP_EN
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
`endif
    endtask

    task automatic test_basic();
        bit g, s, iv; addr_t a, p; instr_t ins;
        do_reset(1'b0);
        mem_txn(0, 0, 16'hA001, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", g); end
        checks++; if (a !== 16'h0000) begin errors++; $display("FAIL basic_addr got %h exp 0000", a); end
        checks++; if (iv !== 1'b1 || ins !== 16'hA001) begin errors++; $display("FAIL basic_instr got %b/%h exp 1/a001", iv, ins); end
        checks++; if (p !== 16'h0001) begin errors++; $display("FAIL basic_pc got %h exp 0001", p); end
        model_pc = 16'h0001;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = 16'($urandom);
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold got valid %b iv %b exp 0/0", imem_req_valid, instr_valid); end
        end
        stall = 1'b0; imem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc) begin
            errors++; $display("FAIL stall_release got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, model_pc); end
    endtask

    task automatic test_ready_stall();
        bit g, s, iv; addr_t a, p; instr_t ins;
        do_reset(1'b0);
        mem_txn(3, 1, 16'h5C3A, 1'b0, '0, 1'b0, 1'b1, g, a, s, iv, ins, p);
        checks++; if (g !== 1'b1 || a !== 16'h0000) begin errors++; $display("FAIL ready_addr got %b/%h exp 1/0000", g, a); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL ready_stable got %b exp 1", s); end
        checks++; if (iv !== 1'b1 || ins !== 16'h5C3A || p !== 16'h0001) begin
            errors++; $display("FAIL ready_rsp got %b/%h/%h exp 1/5c3a/0001", iv, ins, p); end
    endtask

    task automatic test_branch();
        bit g, s, iv; addr_t a, p; instr_t ins;
        do_reset(1'b0);
        mem_txn(0, 2, 16'h1111, 1'b1, 16'h0040, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (iv !== 1'b0 || p !== 16'h0040) begin errors++; $display("FAIL br_wait_drop got %b/%h exp 0/0040", iv, p); end
        mem_txn(1, 0, 16'h2222, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (a !== 16'h0040 || iv !== 1'b1 || p !== 16'h0041) begin
            errors++; $display("FAIL br_wait_next got %h/%b/%h exp 0040/1/0041", a, iv, p); end
        mem_txn(0, 0, 16'h3333, 1'b1, 16'h0123, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (iv !== 1'b0 || p !== 16'h0123) begin errors++; $display("FAIL br_same_cycle got %b/%h exp 0/0123", iv, p); end
        idle_branch(16'h0200);
        checks++; if (pc_out !== 16'h0200) begin errors++; $display("FAIL br_idle_pc got %h exp 0200", pc_out); end
        mem_txn(0, 1, 16'h4444, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (a !== 16'h0200 || iv !== 1'b1 || ins !== 16'h4444 || p !== 16'h0201) begin
            errors++; $display("FAIL br_idle_nopend got %h/%b/%h/%h exp 0200/1/4444/0201", a, iv, ins, p); end
    endtask

    task automatic test_halt();
        bit g, s, iv; addr_t a, p; instr_t ins;
        do_reset(1'b0);
        mem_txn(0, 2, 16'h1234, 1'b0, '0, 1'b1, 1'b0, g, a, s, iv, ins, p);
        checks++; if (iv !== 1'b1 || ins !== 16'h1234) begin errors++; $display("FAIL halt_deliver got %b/%h exp 1/1234", iv, ins); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_state got %b exp 1", halted); end
        for (int i = 0; i < 8; i++) begin
            branch_taken = 1'($urandom); branch_target = 16'($urandom);
            imem_req_ready = 1'b1; imem_rsp_valid = 1'($urandom);
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 16'h0001 || halted !== 1'b1) begin
                errors++; $display("FAIL halt_frozen got v%b iv%b pc%h h%b exp 0/0/0001/1",
                                   imem_req_valid, instr_valid, pc_out, halted); end
        end
        clear_inputs();
        do_reset(1'b1);
        @(negedge clk);
        halt_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL halt_idle got %b/%b exp 1/0", halted, imem_req_valid); end
    endtask

    task automatic test_wrap();
        bit g, s, iv; addr_t a, p; instr_t ins;
        do_reset(1'b0);
        mem_txn(0, 0, 16'h0F0F, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        idle_branch(16'hFFFF);
        mem_txn(1, 1, 16'hC0DE, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (a !== 16'hFFFF || iv !== 1'b1 || ins !== 16'hC0DE) begin
            errors++; $display("FAIL wrap_deliver got %h/%b/%h exp ffff/1/c0de", a, iv, ins); end
`ifdef PC_WRAP_TRAP_EN
        checks++; if (p !== 16'hFFFF || halted !== 1'b1 || fetch_fault !== 1'b1) begin
            errors++; $display("FAIL wrap_trap got %h/%b/%b exp ffff/1/1", p, halted, fetch_fault); end
`else
        checks++; if (p !== 16'h0000 || halted !== 1'b0) begin
            errors++; $display("FAIL wrap_pc got %h/%b exp 0000/0", p, halted); end
        mem_txn(0, 0, 16'h7777, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        checks++; if (a !== 16'h0000 || iv !== 1'b1) begin errors++; $display("FAIL wrap_next got %h/%b exp 0000/1", a, iv); end
`endif
    endtask

    task automatic test_reset_wait();
        bit g, s, iv, seen; addr_t a, p; instr_t ins;
        do_reset(1'b0);
        mem_txn(0, 0, 16'h9999, 1'b0, '0, 1'b0, 1'b0, g, a, s, iv, ins, p);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (imem_req_valid === 1'b1) seen = 1'b1; else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstwait_req got 0 exp 1"); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (pc_out !== RV || imem_req_valid !== 1'b0 || instr !== 16'h0000 || halted !== 1'b0) begin
            errors++; $display("FAIL rstwait_async got pc%h v%b i%h h%b exp %h/0/0000/0", pc_out, imem_req_valid, instr, halted, RV); end
        @(negedge clk);
        rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 16'hBEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin
            errors++; $display("FAIL rstwait_stale got %b/%h exp 0/0000", instr_valid, instr); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RV) begin
            errors++; $display("FAIL rstwait_reissue got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, RV); end
        model_pc = RV;
    endtask

    task automatic test_random();
        bit g, s, iv, br, tog; addr_t a, p, tgt; instr_t ins, data; int rd, rs;
        do_reset(1'b0);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                tgt = 16'($urandom_range(0, 16'h7FFF));
                idle_branch(tgt);
                model_pc = tgt;
            end
            rd = $urandom_range(0, 3); rs = $urandom_range(0, 3);
            data = 16'($urandom); br = ($urandom_range(0, 3) == 0);
            tgt = 16'($urandom_range(0, 16'h7FFF)); tog = 1'($urandom);
            mem_txn(rd, rs, data, br, tgt, 1'b0, tog, g, a, s, iv, ins, p);
            checks++; if (g !== 1'b1 || a !== model_pc || s !== 1'b1) begin
                errors++; $display("FAIL rand_req[%0d] got %b/%h/%b exp 1/%h/1", n, g, a, s, model_pc); end
            if (br) begin
                checks++; if (iv !== 1'b0 || p !== tgt) begin
                    errors++; $display("FAIL rand_br[%0d] got %b/%h exp 0/%h", n, iv, p, tgt); end
                model_pc = tgt;
            end else begin
                checks++; if (iv !== 1'b1 || ins !== data || p !== model_pc + 16'd1) begin
                    errors++; $display("FAIL rand_seq[%0d] got %b/%h/%h exp 1/%h/%h", n, iv, ins, p, data, model_pc + 16'd1); end
                model_pc = model_pc + 16'd1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ready_stall();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_VECTOR, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pc_out  output  16  current PC; drives pc_adder current_address.
REQ-005 next_address  input  16  sequential successor of pc_out from pc_adder.
REQ-006 branch_taken  input  1  redirect request, one-cycle qualifier for branch_target.
REQ-007 branch_target  input  16  redirect PC.
REQ-008 stall  input  1  suppresses issue of a new fetch request.
REQ-009 halt_req  input  1  stop fetching; sticky until reset.
REQ-010 imem_req_valid  output  1  fetch request valid.
REQ-011 imem_req_addr  output  16  fetch address.
REQ-012 imem_req_ready  input  1  instruction memory accepts request.
REQ-013 imem_rsp_valid  input  1  response data valid.
REQ-014 imem_rsp_data  input  16  fetched instruction word.
REQ-015 instr_valid  output  1  one-cycle pulse, instr holds a valid instruction.
REQ-016 instr  output  16  fetched instruction, held until next instr_valid.
REQ-017 halted  output  1  unit in HALT state.
REQ-018 fetch_fault  output  1  PC wrap trap (present only with PC_WRAP_TRAP_EN).

Function
REQ-019 FSM states SHALL be S_REQ, S_WAIT, S_HALT; reset state S_REQ.
REQ-020 S_REQ: imem_req_valid SHALL rise the cycle after entry when stall=0 and no halt pending; while stall=1 and valid=0, valid stays 0.
REQ-021 Once imem_req_valid=1, it and imem_req_addr (=pc_out) SHALL hold stable until imem_req_valid&&imem_req_ready; stall ignored meanwhile.
REQ-022 On handshake, valid SHALL drop next cycle and FSM SHALL enter S_WAIT; max one outstanding request.
REQ-023 imem_rsp_valid SHALL be ignored outside S_WAIT.
REQ-024 S_WAIT on imem_rsp_valid with no redirect pending: instr<=imem_rsp_data, instr_valid=1 next cycle, pc_out<=next_address, go S_REQ.
REQ-025 branch_taken in any non-HALT state SHALL latch branch_target into a pending redirect; a later branch_taken overwrites it.
REQ-026 Response with redirect pending (or branch_taken same cycle): response dropped (instr_valid stays 0), pc_out<=latest target, pending cleared, go S_REQ.
REQ-027 branch_taken in S_REQ with valid=0 SHALL update pc_out directly next cycle, no pending entry.
REQ-028 halt_req in S_REQ with valid=0: go S_HALT; in S_REQ with valid=1 or in S_WAIT: pending, applied after the response completes (instruction still delivered).
REQ-029 S_HALT: valid=0, instr_valid=0, pc_out frozen, halted=1; exit only by reset.
REQ-030 pc_out arithmetic is 16-bit; without trap, 16'hFFFF successor 16'h0000 is accepted.

Reset
REQ-031 rst_n low SHALL immediately force: pc_out=RESET_VECTOR, imem_req_valid=0, instr_valid=0, instr=16'h0000, halted=0, fetch_fault=0, redirect and halt pending cleared, state S_REQ.
REQ-032 Response arriving after a mid-transaction reset SHALL be discarded (REQ-023).

Configuration
REQ-033 Macro PC_WRAP_TRAP_EN defined: when a sequential update has next_address < pc_out, the instruction SHALL be delivered, pc_out SHALL hold, fetch_fault=1 (sticky), FSM enters S_HALT.
REQ-034 Macro undefined: fetch_fault port absent, wrap behaves per REQ-030.

Structure
REQ-035 Shared package cpu_pkg SHALL hold addr_t/instr_t (16-bit) typedefs, fetch_state_t enum, and default RESET_VECTOR constant.
REQ-036 One sub-module: pc_adder instantiated externally; pc_fetch_unit contains no adder.

Verification
REQ-037 Reset, ready=1, rsp one cycle after handshake with 16'hA001 -> addr 16'h0000, instr=16'hA001 pulse, pc_out=16'h0001.
REQ-038 ready low 3 cycles, stall toggled meanwhile -> valid and addr 16'h0000 stable, single handshake.
REQ-039 branch_taken target 16'h0040 during S_WAIT -> response dropped, next req addr 16'h0040.
REQ-040 halt_req during S_WAIT -> instruction delivered, then halted=1, no further requests.
REQ-041 pc_out=16'hFFFF: with macro -> fetch_fault=1, halted=1; without -> next addr 16'h0000.
REQ-042 rst_n low in S_WAIT, stale rsp_valid after release -> ignored, addr RESET_VECTOR reissued.
